// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: control-flow selects, adder sum and imem handshake in; PC, request and status out.
// master is the fetch unit; slave is the surrounding core, adder and instruction memory.
interface pc_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump_reg;
  logic [DATA_WIDTH-1:0] jalr_target;
  logic [DATA_WIDTH-1:0] pc_plus4_in;
  logic                  imem_ready;
  logic [DATA_WIDTH-1:0] pc_out;
  logic                  imem_req;
  logic                  instr_valid;
  logic                  misalign_err;

  modport master (
    input  stall, branch_taken, branch_target, jump_reg, jalr_target, pc_plus4_in, imem_ready,
    output pc_out, imem_req, instr_valid, misalign_err
  );

  modport slave (
    output stall, branch_taken, branch_target, jump_reg, jalr_target, pc_plus4_in, imem_ready,
    input  pc_out, imem_req, instr_valid, misalign_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-PC select feeding an external +4 adder. One BOOT cycle after reset, then the PC advances
// on the same edge that accepts an instruction. Stall or a missing imem_ready holds the PC indefinitely.
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] target;
  logic                  req_q;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  from_branch;
  logic                  target_bad;

  // Next-PC candidate; only consulted on cycles where an instruction is accepted.
  always_comb begin
    accept      = (state_q == FETCH) & bus.imem_ready & ~bus.stall;
    from_branch = 1'b0;
    target      = bus.pc_plus4_in;
    if (bus.jump_reg) begin
      target    = bus.jalr_target;
      target[0] = 1'b0;
    end else if (bus.branch_taken) begin
      target      = bus.branch_target;
      from_branch = 1'b1;
    end
    // No compressed instructions: bit 1 is always illegal; bit 0 only reaches us on the branch path.
    target_bad = target[1] | (from_branch & target[0]);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (accept) begin
          if (target_bad) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = target;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == FETCH);
      err_q   <= err_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.imem_req     = req_q;
  assign bus.misalign_err = err_q;
  assign bus.instr_valid  = accept;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the 32-bit PC adder.
- Holds the architectural PC and drives it to the adder's `a` input; the adder's `b` input is tied to 4.
- Consumes the adder's sum (PC+4), selects the next PC from sequential, branch and JALR sources, and issues instruction-memory fetch requests with a ready handshake.
- Flags misaligned control-flow targets and halts fetch until reset.

Parameters:
- DATA_WIDTH, 32: width of PC, targets and addresses.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC; suppress the PC update even if imem_ready is high.
- branch_taken  input  1  select branch_target as next PC.
- branch_target  input  DATA_WIDTH  PC-relative branch/JAL target.
- jump_reg  input  1  select the JALR target as next PC.
- jalr_target  input  DATA_WIDTH  rs1+imm sum, before LSB clearing.
- pc_plus4_in  input  DATA_WIDTH  adder output (pc_out + 4).
- imem_ready  input  1  instruction memory returns data this cycle.
- pc_out  output  DATA_WIDTH  current PC, to the adder and imem address.
- imem_req  output  1  fetch request for address pc_out.
- instr_valid  output  1  instruction at pc_out accepted this cycle.
- misalign_err  output  1  sticky flag for a misaligned target.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following values:
  - pc_out = RESET_VECTOR
  - state = BOOT
  - imem_req = 0, instr_valid = 0, misalign_err = 0
- FSM states are BOOT, FETCH and HALT. All outputs are registered except instr_valid.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts.
  - imem_req = 0.
  - Moves to FETCH unconditionally. pc_out is not changed.
- FETCH:
  - imem_req = 1 continuously.
  - instr_valid = imem_ready & ~stall (combinational).
  - On a cycle with instr_valid = 1, the next PC is selected by fixed priority:
    1. jump_reg: {jalr_target[DATA_WIDTH-1:1], 1'b0}
    2. branch_taken: branch_target
    3. otherwise: pc_plus4_in
  - If jump_reg and branch_taken are both high, jump_reg wins.
  - Alignment check (no compressed-ISA support): if the selected next PC has bit 1 set, or bit 0 set on the branch path:
    - pc_out holds its current value.
    - misalign_err is set to 1 on the next edge.
    - The FSM moves to HALT.
  - If the selected next PC is aligned, pc_out loads it on the clock edge and the FSM stays in FETCH.
  - stall = 1: pc_out holds and instr_valid = 0 regardless of imem_ready; imem_req stays 1.
  - imem_ready = 0: pc_out holds, i.e. wait states of unbounded length.
  - branch_taken and jump_reg are ignored on cycles with instr_valid = 0.
- HALT:
  - imem_req = 0, instr_valid = 0.
  - pc_out frozen at the address of the offending instruction.
  - misalign_err = 1.
  - Leaves HALT only via rst_n.
- Arithmetic:
  - All PC values are unsigned DATA_WIDTH bits.
  - Wrap-around from 32'hFFFF_FFFC to 32'h0000_0000 comes from the adder and is accepted as normal.
  - The block performs no addition itself.
- Reset mid-operation:
  - Asserting rst_n in any state immediately drives the reset values.
  - An in-flight fetch is abandoned; the memory must tolerate imem_req dropping without ready.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET_VECTOR = 0; release rst_n; imem_ready = 1 from cycle 2.
  - Response: imem_req = 0 in the BOOT cycle; then pc_out = 0x0, 0x4, 0x8, 0xC on consecutive cycles, with instr_valid = 1 each cycle.
- Stall and wait states:
  - Stimulus: at pc 0x10, stall = 1 for 3 cycles, then imem_ready = 0 for 2 cycles.
  - Response: pc_out stays 0x10 for 5 cycles with instr_valid = 0; it advances to 0x14 on the first accepted cycle.
- Priority:
  - Stimulus: at pc 0x20, jump_reg = 1 with jalr_target = 0x101, and branch_taken = 1 with branch_target = 0x40, same cycle.
  - Response: next pc_out = 0x100 (LSB cleared, branch ignored).
- Misaligned branch:
  - Stimulus: at pc 0x30, branch_taken = 1, branch_target = 0x36.
  - Response: misalign_err = 1 next cycle; pc_out stays 0x30; imem_req = 0 thereafter; no further change until rst_n.
- Wrap-around:
  - Stimulus: pc 0xFFFF_FFFC, pc_plus4_in = 0x0000_0000, imem_ready = 1.
  - Response: pc_out = 0x0, misalign_err stays 0.
- Async reset mid-fetch:
  - Stimulus: drop rst_n between clock edges while in FETCH at pc 0x80.
  - Response: pc_out = RESET_VECTOR and imem_req = 0 immediately, before the next edge.
